poly_nco: RTL and testbench

//  Time-multiplexed polyphonic NCO: NUM_VOICES phase accumulators share one shaper and one multiplier.
//  Per voice: frequency word, gain (driven by the external envelope), waveform shape and pulse width.
//  One frame per sample_tick: every voice advances one phase step, outputs are gain-scaled and mixed.

---
 rtl/poly_nco_pkg.sv | 13 +
 rtl/poly_nco_if.sv | 31 +++
 rtl/nco_shaper.sv | 34 +++
 rtl/poly_nco.sv | 214 +++++++++++++++++++++
 tb/tb_poly_nco.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/poly_nco_pkg.sv
// rtl/poly_nco_pkg.sv - shared types and constants for the polyphonic NCO
package poly_nco_pkg;

    localparam int OUT_W = 16;

    typedef enum logic [1:0] {SAW, SQUARE, TRI, PULSE} shape_e;
    typedef enum logic [1:0] {CFG_FREQ, CFG_GAIN, CFG_SHAPE, CFG_PW} cfg_sel_e;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    localparam logic signed [OUT_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [OUT_W-1:0] SAT_MIN = 16'sh8000;

endpackage

// File: rtl/poly_nco_if.sv
// rtl/poly_nco_if.sv - tick/config inputs and voice/mix outputs of poly_nco
// Ports: sample_tick, cfg_we/cfg_voice/cfg_sel/cfg_data (towards the NCO);
//        voice_out/voice_idx/voice_valid, mix_out/mix_valid, overrun (from the NCO).
interface poly_nco_if #(
    parameter int NUM_VOICES = 8,
    parameter int PHASE_W    = 24
);
    localparam int VW = $clog2(NUM_VOICES);

    logic                sample_tick;
    logic                cfg_we;
    logic [VW-1:0]       cfg_voice;
    logic [1:0]          cfg_sel;
    logic [PHASE_W-1:0]  cfg_data;
    logic signed [15:0]  voice_out;
    logic [VW-1:0]       voice_idx;
    logic                voice_valid;
    logic signed [15:0]  mix_out;
    logic                mix_valid;
    logic                overrun;

    modport master (
        output sample_tick, cfg_we, cfg_voice, cfg_sel, cfg_data,
        input  voice_out, voice_idx, voice_valid, mix_out, mix_valid, overrun
    );

    modport slave (
        input  sample_tick, cfg_we, cfg_voice, cfg_sel, cfg_data,
        output voice_out, voice_idx, voice_valid, mix_out, mix_valid, overrun
    );
endinterface

// File: rtl/nco_shaper.sv
// rtl/nco_shaper.sv - combinational waveform shaper: (p16, shape, pw) -> signed wave
// Ports: p16 top 16 phase bits, shape waveform select, pw pulse width, wave signed output.
module nco_shaper
    import poly_nco_pkg::*;
(
    input  logic [OUT_W-1:0]        p16,
    input  shape_e                  shape,
    input  logic [OUT_W-1:0]        pw,
    output logic signed [OUT_W-1:0] wave
);
    logic [OUT_W-1:0] ramp;
    logic [OUT_W-1:0] tri_w;
    logic [OUT_W-1:0] pw_eff;

    always_comb begin
        // 2*p16 - 0x8000 in 16-bit arithmetic is a left shift with the MSB flipped.
        ramp  = {p16[OUT_W-2:0], 1'b0} ^ 16'h8000;
        // Second half of the period mirrors the first by bitwise inversion, which
        // keeps the fold continuous at the peak (0x7FFF) and the trough.
        tri_w = p16[OUT_W-1] ? ~ramp : ramp;
        if (tri_w == 16'h8000) begin
            tri_w = 16'h8001;
        end
        pw_eff = (shape == SQUARE) ? 16'h8000 : pw;

        wave = '0;
        case (shape)
            SAW:           wave = $signed(p16 ^ 16'h8000);
            SQUARE, PULSE: wave = (p16 < pw_eff) ? 16'sh7FFF : -16'sh7FFF;
            TRI:           wave = $signed(tri_w);
            default:       wave = '0;
        endcase
    end
endmodule

// File: rtl/poly_nco.sv
// rtl/poly_nco.sv - time-multiplexed polyphonic NCO with gain scaling and saturated mix
// Ports: Clk, Reset (sync, active-high), bus (poly_nco_if.slave: tick, config, voice and mix streams).
// Optional feature: POLY_NCO_RETRIG_EN - freq write with cfg_data MSB clear zeroes that voice's phase.
module poly_nco
    import poly_nco_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int PHASE_W    = 24
) (
    input logic       Clk,
    input logic       Reset,
    poly_nco_if.slave bus
);
    localparam int VW    = $clog2(NUM_VOICES);
    localparam int ACC_W = OUT_W + VW;

    // ---------------- frame sequencer ----------------
    state_e        state, state_nxt;
    logic [VW-1:0] cnt;
    logic          frame_start, tick_lost, s0_en, s0_last;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.sample_tick)             state_nxt = RUN;
            RUN:     if (cnt == VW'(NUM_VOICES - 1))  state_nxt = DRAIN;
            DRAIN:   if (cnt == VW'(1))               state_nxt = IDLE;
            default:                                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        frame_start = (state == IDLE) && bus.sample_tick;
        tick_lost   = (state != IDLE) && bus.sample_tick;
        s0_en       = (state == RUN);
        s0_last     = (state == RUN) && (cnt == VW'(NUM_VOICES - 1));
    end

    // cnt is the voice index in RUN and the drain cycle count in DRAIN.
    always_ff @(posedge Clk) begin
        if (Reset || (state != state_nxt)) cnt <= '0;
        else if (state != IDLE)            cnt <= cnt + VW'(1);
    end

    // ---------------- per-voice configuration ----------------
    logic [PHASE_W-1:0] freq_q  [NUM_VOICES];
    logic [OUT_W-1:0]   gain_q  [NUM_VOICES];
    shape_e             shape_q [NUM_VOICES];
    logic [OUT_W-1:0]   pw_q    [NUM_VOICES];
    logic [PHASE_W-1:0] phase_q [NUM_VOICES];

    logic [PHASE_W-1:0] cfg_freq;
    logic               cfg_retrig;

`ifdef POLY_NCO_RETRIG_EN
    assign cfg_freq   = {1'b0, bus.cfg_data[PHASE_W-2:0]};
    assign cfg_retrig = bus.cfg_we && (bus.cfg_sel == CFG_FREQ) && !bus.cfg_data[PHASE_W-1];
`else
    assign cfg_freq   = bus.cfg_data;
    assign cfg_retrig = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                freq_q[i]  <= '0;
                gain_q[i]  <= '0;
                shape_q[i] <= SAW;
                pw_q[i]    <= '0;
            end
        end else if (bus.cfg_we) begin
            case (bus.cfg_sel)
                CFG_FREQ:  freq_q[bus.cfg_voice]  <= cfg_freq;
                CFG_GAIN:  gain_q[bus.cfg_voice]  <= bus.cfg_data[OUT_W-1:0];
                CFG_SHAPE: shape_q[bus.cfg_voice] <= shape_e'(bus.cfg_data[1:0]);
                CFG_PW:    pw_q[bus.cfg_voice]    <= bus.cfg_data[OUT_W-1:0];
                default:   ;
            endcase
        end
    end

    // ---------------- S0: read voice state ----------------
    logic               s1_valid, s1_last, s1_zero;
    logic [VW-1:0]      s1_idx;
    logic [PHASE_W-1:0] s1_phase, s1_freq;
    shape_e             s1_shape;
    logic [OUT_W-1:0]   s1_pw, s1_gain;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_idx   <= '0;
            s1_phase <= '0;
            s1_freq  <= '0;
            s1_shape <= SAW;
            s1_pw    <= '0;
            s1_gain  <= '0;
        end else begin
            s1_valid <= s0_en;
            s1_last  <= s0_last;
            // A retrigger landing on the voice being read must not be undone by
            // the write-back of the old phase one cycle later.
            s1_zero  <= s0_en && cfg_retrig && (bus.cfg_voice == cnt);
            s1_idx   <= cnt;
            s1_phase <= phase_q[cnt];
            s1_freq  <= freq_q[cnt];
            s1_shape <= shape_q[cnt];
            s1_pw    <= pw_q[cnt];
            s1_gain  <= gain_q[cnt];
        end
    end

    // ---------------- S1: shape and phase write-back ----------------
    logic signed [OUT_W-1:0] s1_wave;

    nco_shaper u_shaper (
        .p16   (s1_phase[PHASE_W-1 -: OUT_W]),
        .shape (s1_shape),
        .pw    (s1_pw),
        .wave  (s1_wave)
    );

    // Config-side zeroing is written last so it wins over a same-cycle write-back.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= '0;
        end else begin
            if (s1_valid) phase_q[s1_idx] <= s1_zero ? '0 : s1_phase + s1_freq;
            if (cfg_retrig) phase_q[bus.cfg_voice] <= '0;
        end
    end

    logic                    s2_valid, s2_last;
    logic [VW-1:0]           s2_idx;
    logic signed [OUT_W-1:0] s2_wave;
    logic [OUT_W-1:0]        s2_gain;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_idx   <= '0;
            s2_wave  <= '0;
            s2_gain  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_idx   <= s1_idx;
            s2_wave  <= s1_wave;
            s2_gain  <= s1_gain;
        end
    end

    // ---------------- S2: gain multiply and mix ----------------
    logic signed [2*OUT_W:0]  prod;
    logic signed [OUT_W-1:0]  scaled;
    logic [ACC_W-1:0]         acc;
    logic signed [OUT_W-1:0]  acc_sat;
    logic                     mix_last;

    // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
    assign prod   = s2_wave * $signed({1'b0, s2_gain});
    assign scaled = OUT_W'(prod >>> OUT_W);

    always_comb begin
        if ((&acc[ACC_W-1:OUT_W-1]) || !(|acc[ACC_W-1:OUT_W-1])) acc_sat = $signed(acc[OUT_W-1:0]);
        else if (acc[ACC_W-1])                                   acc_sat = SAT_MIN;
        else                                                     acc_sat = SAT_MAX;
    end

    logic signed [OUT_W-1:0] voice_out_q, mix_out_q;
    logic [VW-1:0]           voice_idx_q;
    logic                    voice_valid_q, mix_valid_q, overrun_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            voice_out_q   <= '0;
            voice_idx_q   <= '0;
            voice_valid_q <= 1'b0;
            acc           <= '0;
            mix_last      <= 1'b0;
            mix_out_q     <= '0;
            mix_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            voice_valid_q <= s2_valid;
            if (s2_valid) begin
                voice_out_q <= scaled;
                voice_idx_q <= s2_idx;
            end
            if (frame_start)   acc <= '0;
            else if (s2_valid) acc <= acc + {{VW{scaled[OUT_W-1]}}, scaled};
            mix_last    <= s2_valid && s2_last;
            mix_valid_q <= mix_last;
            if (mix_last) mix_out_q <= acc_sat;
            if (tick_lost) overrun_q <= 1'b1;
        end
    end

    assign bus.voice_out   = voice_out_q;
    assign bus.voice_idx   = voice_idx_q;
    assign bus.voice_valid = voice_valid_q;
    assign bus.mix_out     = mix_out_q;
    assign bus.mix_valid   = mix_valid_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_poly_nco.sv
// tb/tb_poly_nco.sv - scoreboard testbench for poly_nco
module tb_poly_nco;
    localparam int NV = 8;
    localparam int PW = 24;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    poly_nco_if #(.NUM_VOICES(NV), .PHASE_W(PW)) bus ();
    poly_nco #(.NUM_VOICES(NV), .PHASE_W(PW)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [PW-1:0] m_phase [NV];
    logic [PW-1:0] m_freq  [NV];
    logic [15:0]   m_gain  [NV];
    logic [15:0]   m_pw    [NV];
    logic [1:0]    m_shape [NV];

    typedef struct { int idx; longint val; } vexp_t;
    vexp_t  vq[$];
    longint mq[$];

    function automatic longint m_wave(input logic [15:0] p, input logic [1:0] sh, input logic [15:0] pw);
        longint pi = longint'(p);
        longint w;
        case (sh)
            2'd0: w = pi - 32768;
            2'd1: w = (pi < 32768) ? 32767 : -32767;
            2'd3: w = (pi < longint'(pw)) ? 32767 : -32767;
            default: begin
                if (pi < 32768) w = 2 * pi - 32768;
                else            w = 32767 - 2 * (pi - 32768);
                if (w < -32767) w = -32767;
            end
        endcase
        return w;
    endfunction

    function automatic longint m_scale(input longint w, input logic [15:0] g);
        longint prod = w * longint'(g);
        return prod >>> 16;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NV; k++) begin
            m_phase[k] = '0; m_freq[k] = '0; m_gain[k] = '0; m_pw[k] = '0; m_shape[k] = 2'd0;
        end
    endtask

    task automatic push_frame();
        longint sum = 0;
        longint v;
        for (int k = 0; k < NV; k++) begin
            v = m_scale(m_wave(m_phase[k][PW-1 -: 16], m_shape[k], m_pw[k]), m_gain[k]);
            vq.push_back('{k, v});
            sum += v;
            m_phase[k] = m_phase[k] + m_freq[k];
        end
        if (sum > 32767)  sum = 32767;
        if (sum < -32768) sum = -32768;
        mq.push_back(sum);
    endtask

    // ---------------- monitor ----------------
    int     cyc = 0;
    int     tick_edge = 0;
    int     vv0_cyc = 0, vv_last_cyc = 0, vv_count = 0;
    int     mix_cyc = 0, mix_seen = 0;
    longint mix_last_val = 0;
    vexp_t  e;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (!Reset) begin
            if (bus.voice_valid) begin
                vv_count++;
                if (bus.voice_idx == 0) vv0_cyc = cyc;
                vv_last_cyc = cyc;
                if (vq.size() == 0) begin
                    chk("voice_unexpected", 1, 0);
                end else begin
                    e = vq.pop_front();
                    chk("voice_idx", longint'(bus.voice_idx), longint'(e.idx));
                    chk($sformatf("voice_out[%0d]", e.idx), longint'($signed(bus.voice_out)), e.val);
                end
            end
            if (bus.mix_valid) begin
                mix_seen++;
                mix_cyc = cyc;
                mix_last_val = longint'($signed(bus.mix_out));
                if (mq.size() == 0) chk("mix_unexpected", 1, 0);
                else                chk("mix_out", mix_last_val, mq.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cfg_write(input int v, input int sel, input logic [PW-1:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_voice = 3'(v);
        bus.cfg_sel   = 2'(sel);
        bus.cfg_data  = d;
        case (sel)
            0: begin
`ifdef POLY_NCO_RETRIG_EN
                if (!d[PW-1]) m_phase[v] = '0;
                m_freq[v] = {1'b0, d[PW-2:0]};
`else
                m_freq[v] = d;
`endif
            end
            1: m_gain[v]  = d[15:0];
            2: m_shape[v] = d[1:0];
            default: m_pw[v] = d[15:0];
        endcase
        @(negedge Clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic tick(input bit accept);
        bus.sample_tick = 1'b1;
        if (accept) begin
            tick_edge = cyc + 1;
            push_frame();
        end
        @(negedge Clk);
        bus.sample_tick = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((vq.size() != 0 || mq.size() != 0) && n < 60) begin
            @(negedge Clk);
            n++;
        end
        @(negedge Clk);
        if (vq.size() != 0 || mq.size() != 0) begin
            chk("frame_timeout", 1, 0);
            vq.delete();
            mq.delete();
        end
    endtask

    task automatic frame();
        tick(1'b1);
        wait_done();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_voice_out"},   longint'(bus.voice_out),   0);
        chk({tag, "_voice_idx"},   longint'(bus.voice_idx),   0);
        chk({tag, "_voice_valid"}, longint'(bus.voice_valid), 0);
        chk({tag, "_mix_out"},     longint'(bus.mix_out),     0);
        chk({tag, "_mix_valid"},   longint'(bus.mix_valid),   0);
        chk({tag, "_overrun"},     longint'(bus.overrun),     0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int m0;
        bus.sample_tick = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_voice   = '0;
        bus.cfg_sel     = '0;
        bus.cfg_data    = '0;
        model_reset();
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk_quiet("reset");

        // Idle frame: latencies and all-zero outputs.
        vv_count = 0;
        frame();
        chk("vv_latency",  longint'(vv0_cyc - tick_edge), 3);
        chk("vv_span",     longint'(vv_last_cyc - vv0_cyc), NV - 1);
        chk("vv_count",    longint'(vv_count), NV);
        chk("mix_latency", longint'(mix_cyc - tick_edge), NV + 3);
        chk("mix_zero",    mix_last_val, 0);
        chk("overrun_idle", longint'(bus.overrun), 0);

        // Saw on v0 stepping p16 by 0x1000 and wrapping.
        cfg_write(0, 0, 24'h100000);
        cfg_write(0, 1, 24'h00FFFF);
        cfg_write(0, 2, 24'h000000);
        for (int i = 0; i < 17; i++) frame();

        // Four full-scale pulses saturate the mix; quarter gain just fits.
        for (int v = 0; v < 4; v++) begin
            cfg_write(v, 0, 24'h000000);
            cfg_write(v, 2, 24'h000003);
            cfg_write(v, 3, 24'h00FFFF);
            cfg_write(v, 1, 24'h00FFFF);
        end
        frame();
        chk("mix_sat", mix_last_val, 32767);
        for (int v = 0; v < 4; v++) cfg_write(v, 1, 24'h004000);
        frame();
        chk("mix_quarter", mix_last_val, 32764);

        // Tick during a frame is dropped and flags overrun.
        m0 = mix_seen;
        tick(1'b1);
        repeat (4) @(negedge Clk);
        tick(1'b0);
        wait_done();
        repeat (15) @(negedge Clk);
        chk("overrun_single_mix", longint'(mix_seen - m0), 1);
        chk("overrun_set", longint'(bus.overrun), 1);
        frame();
        chk("overrun_sticky", longint'(bus.overrun), 1);

        // Freq write to v3 on the cycle S0 reads it.
        cfg_write(3, 2, 24'h000000);
        cfg_write(3, 1, 24'h00FFFF);
        cfg_write(3, 0, 24'h040000);
        frame();
        tick(1'b1);
        repeat (3) @(negedge Clk);
        cfg_write(3, 0, 24'h200000);
        wait_done();
        frame();
        frame();

        // Retrigger behaviour (plain write when the macro is absent).
        cfg_write(0, 2, 24'h000000);
        cfg_write(0, 1, 24'h00FFFF);
        cfg_write(0, 0, 24'h100000);
        frame();
        frame();
        cfg_write(0, 0, 24'h100000);
        frame();
        frame();
        cfg_write(0, 0, 24'h900000);
        frame();
        frame();

        // Random mix of shapes, widths, gains and frequencies.
        for (int f = 0; f < 4; f++) begin
            for (int v = 0; v < NV; v++) begin
                cfg_write(v, 0, 24'($urandom));
                cfg_write(v, 1, 24'($urandom));
                cfg_write(v, 2, 24'($urandom_range(0, 3)));
                cfg_write(v, 3, 24'($urandom));
            end
            frame();
            frame();
        end

        // Reset mid-frame: only voices 0 and 1 emerge, no mix.
        m0 = mix_seen;
        bus.sample_tick = 1'b1;
        push_frame();
        while (vq.size() > 2) void'(vq.pop_back());
        mq.delete();
        @(negedge Clk);
        bus.sample_tick = 1'b0;
        repeat (4) @(negedge Clk);
        #1 Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        repeat (20) @(negedge Clk);
        chk("abort_voices_left", longint'(vq.size()), 0);
        chk("abort_no_mix", longint'(mix_seen - m0), 0);
        chk_quiet("abort");
        frame();
        chk("post_abort_mix", mix_last_val, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
